e_mdu: RTL and testbench

- Parametrised multiply/divide unit for the E stage of the pipelined MIPS core.
- Owns architectural HI/LO registers and executes mult/multu/div/divu with configurable multi-cycle latency.
- Exports `busy` so the global stall unit holds any MDU instruction in D while an operation is in flight.
- Adds single-cycle mthi/mtlo writes and a `cancel` input that squashes an in-flight operation.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_calc.sv | 64 ++++++
 rtl/e_mdu.sv | 106 ++++++++++
 tb/tb_e_mdu.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes and classifier for the multiply/divide unit
package mdu_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    // True for every op that touches HI/LO; undefined codes and NONE are not MDU-class.
    function automatic logic is_mdu_class(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd6);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational mult/div result for the HI/LO shadow
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_wr
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic                 sgn;
    logic                 neg_a;
    logic                 neg_b;
    logic [2*WIDTH-1:0]   ext_a;
    logic [2*WIDTH-1:0]   ext_b;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     div_b;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;

    // Signed ops work on magnitudes and fix signs afterwards; the most-negative / -1
    // case falls out naturally because the negated quotient wraps to most-negative.
    // A zero divisor is replaced by one only to keep the divider defined; its result is not written.
    always_comb begin
        sgn    = (op == MDU_MULT) || (op == MDU_DIV);
        neg_a  = sgn & a[WIDTH-1];
        neg_b  = sgn & b[WIDTH-1];
        ext_a  = {{WIDTH{neg_a}}, a};
        ext_b  = {{WIDTH{neg_b}}, b};
        prod   = ext_a * ext_b;
        mag_a  = neg_a ? (~a + ONE) : a;
        mag_b  = neg_b ? (~b + ONE) : b;
        div_b  = (b == '0) ? ONE : mag_b;
        quo    = mag_a / div_b;
        rem    = mag_a % div_b;
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
                res_wr = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                res_lo = (neg_a ^ neg_b) ? (~quo + ONE) : quo;
                res_hi = neg_a ? (~rem + ONE) : rem;
                res_wr = (b != '0);
            end
            default: begin
                res_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit owning HI/LO with multi-cycle busy
module e_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] sh_hi_q, sh_hi_d;
    logic [WIDTH-1:0] sh_lo_q, sh_lo_d;
    logic             sh_wr_q, sh_wr_d;

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_wr;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .res_wr (res_wr)
    );

    // Sequencing: cancel beats everything, RUN counts down and commits on 1->0, IDLE accepts.
    always_comb begin
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        sh_wr_d = sh_wr_q;
        if (cancel) begin
            cnt_d   = '0;
            sh_wr_d = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1) && sh_wr_q) begin
                hi_d = sh_hi_q;
                lo_d = sh_lo_q;
            end
        end else if (start && is_mdu_class(op)) begin
            case (op)
                MDU_MULT, MDU_MULTU: begin
                    sh_hi_d = res_hi;
                    sh_lo_d = res_lo;
                    sh_wr_d = res_wr;
                    cnt_d   = CNT_W'(MULT_LAT);
                end
                MDU_DIV, MDU_DIVU: begin
                    sh_hi_d = res_hi;
                    sh_lo_d = res_lo;
                    sh_wr_d = res_wr;
                    cnt_d   = CNT_W'(DIV_LAT);
                end
                MDU_MTHI: hi_d = a;
                MDU_MTLO: lo_d = a;
                default:  cnt_d = cnt_q;
            endcase
        end
        busy_d = (cnt_d != '0);
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
            sh_wr_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            sh_wr_q <= sh_wr_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed-vector self-checking bench for e_mdu
module tb_e_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;
    int nb;

    e_mdu #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = MDU_NONE;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input int lat,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        issue(o, va, vb);
        count_busy(n);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = MDU_NONE;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("divu", MDU_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);

        issue(MDU_MTHI, 32'h11, 32'h0);
        @(negedge clk);
        chk("mthi_hi", hi, 32'h11);
        chk("mthi_busy", 32'(busy), 32'h0);
        issue(MDU_MTLO, 32'h22, 32'h0);
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h22);

        run_op("div0", MDU_DIV, 32'd50, 32'd0, 10, 32'h11, 32'h22);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", 32'(busy), 32'h0);
        chk("cancel_hi", hi, 32'h0);
        chk("cancel_lo", lo, 32'h8000_0000);
        issue(MDU_MTLO, 32'd5, 32'h0);
        @(negedge clk);
        chk("post_cancel_mtlo", lo, 32'd5);
        repeat (8) @(negedge clk);
        chk("cancel_no_late_hi", hi, 32'h0);
        chk("cancel_no_late_lo", lo, 32'd5);

        @(negedge clk);
        cancel = 1'b1;
        start  = 1'b1;
        op     = MDU_MTHI;
        a      = 32'h77;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        start  = 1'b0;
        op     = MDU_NONE;
        @(negedge clk);
        chk("cancel_beats_mthi", hi, 32'h0);

        issue(MDU_MULT, 32'd2, 32'd3);
        @(negedge clk);
        start = 1'b1;
        op    = MDU_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = MDU_NONE;
        count_busy(nb);
        chk("busy_start_lat", 32'(nb + 1), 32'd5);
        chk("busy_start_hi", hi, 32'h0);
        chk("busy_start_lo", lo, 32'd6);

        issue(MDU_MULT, 32'd5, 32'd5);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("arst_discard_lo", lo, 32'h0);
        chk("arst_discard_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
